sparse_mac_accumulator: RTL and testbench

- Stage directly downstream of the priority-encoder top.
- Consumes the stream of matched bit positions (one per cycle) and converts each position into indices into the compressed IFM and filter data vectors, using the prefix popcount of each sparsity map.
- Multiplies the selected signed operands and accumulates them over one chunk.
- Emits one partial sum per chunk when the encoder's last flag arrives.

---
 rtl/sparse_mac_accumulator.sv | 132 +++++++++++++
 tb/tb_sparse_mac_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sparse_mac_accumulator.sv
// Sparse MAC accumulator: maps matched bit positions to compressed operand indices,
// multiplies and accumulates per chunk. Optional saturating add via SPARSE_MAC_SATURATE_EN.
module sparse_mac_accumulator #(
    parameter int PREFIX_SUM_SIZE = 128,
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 24
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  match_valid_i,
    input  logic [$clog2(PREFIX_SUM_SIZE)-1:0]    match_addr_i,
    input  logic                                  last_i,
    input  logic [PREFIX_SUM_SIZE-1:0]            ifm_map_i,
    input  logic [PREFIX_SUM_SIZE-1:0]            flt_map_i,
    input  logic [PREFIX_SUM_SIZE*DATA_WIDTH-1:0] ifm_data_i,
    input  logic [PREFIX_SUM_SIZE*DATA_WIDTH-1:0] flt_data_i,
    output logic                                  result_valid_o,
    output logic [ACC_WIDTH-1:0]                  result_o,
    output logic [$clog2(PREFIX_SUM_SIZE):0]      match_cnt_o,
    output logic                                  busy_o
);

    localparam int AW = $clog2(PREFIX_SUM_SIZE);
    localparam int CW = AW + 1;

    // Number of set map bits strictly below pos; this is the compressed-vector index.
    function automatic logic [AW-1:0] prefix_count(input logic [PREFIX_SUM_SIZE-1:0] map,
                                                   input logic [AW-1:0] pos);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
            if (i < int'(pos)) c = c + AW'(map[i]);
        end
        return c;
    endfunction

    logic [AW-1:0]                ifm_idx_q, flt_idx_q;
    logic                         v1_q, l1_q, v2_q, l2_q;
    logic signed [ACC_WIDTH-1:0]  prod_q, acc_q;
    logic [CW-1:0]                cnt_q;

    logic signed [DATA_WIDTH-1:0]   ifm_op, flt_op;
    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [ACC_WIDTH-1:0]    prod_d, sum;
    logic [CW-1:0]                  cnt_next;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        ifm_op    = '0;
        flt_op    = '0;
        ifm_op    = ifm_data_i[ifm_idx_q*DATA_WIDTH +: DATA_WIDTH];
        flt_op    = flt_data_i[flt_idx_q*DATA_WIDTH +: DATA_WIDTH];
        prod_full = ifm_op * flt_op;
        prod_d    = v1_q ? ACC_WIDTH'(prod_full) : '0;
    end

`ifdef SPARSE_MAC_SATURATE_EN
    logic signed [ACC_WIDTH:0] sum_wide;
    logic                      ovf;
    logic                      ovf_q;

    always_comb begin
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {prod_q[ACC_WIDTH-1], prod_q};
        ovf      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        sum      = sum_wide[ACC_WIDTH-1:0];
        if (ovf) begin
            // Sign of the wide result tells which rail was crossed.
            sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      ovf_q <= 1'b0;
        else if (l2_q)  ovf_q <= 1'b0;
        else            ovf_q <= ovf_q | ovf;
    end
`else
    always_comb begin
        sum = acc_q + prod_q;
    end
`endif

    always_comb begin
        cnt_next = cnt_q + CW'(v2_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifm_idx_q <= '0;
            flt_idx_q <= '0;
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            prod_q    <= '0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
        end else begin
            ifm_idx_q <= prefix_count(ifm_map_i, match_addr_i);
            flt_idx_q <= prefix_count(flt_map_i, match_addr_i);
            v1_q      <= match_valid_i;
            l1_q      <= last_i;
            prod_q    <= prod_d;
            v2_q      <= v1_q;
            l2_q      <= l1_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            match_cnt_o    <= '0;
        end else begin
            result_valid_o <= l2_q;
            if (l2_q) begin
                result_o    <= sum;
                match_cnt_o <= cnt_next;
                acc_q       <= '0;
                cnt_q       <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_next;
            end
        end
    end

    assign busy_o = v1_q | v2_q | l1_q | l2_q | (cnt_q != '0);

endmodule

// File: tb/tb_sparse_mac_accumulator.sv
// Directed testbench for sparse_mac_accumulator (PREFIX_SUM_SIZE=8, ACC_WIDTH=16).
module tb_sparse_mac_accumulator;

    localparam int PSS = 8;
    localparam int DW  = 8;
    localparam int ACW = 16;
    localparam int AW  = $clog2(PSS);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              match_valid_i;
    logic [AW-1:0]     match_addr_i;
    logic              last_i;
    logic [PSS-1:0]    ifm_map_i, flt_map_i;
    logic [PSS*DW-1:0] ifm_data_i, flt_data_i;
    logic              result_valid_o;
    logic [ACW-1:0]    result_o;
    logic [AW:0]       match_cnt_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sparse_mac_accumulator #(
        .PREFIX_SUM_SIZE(PSS),
        .DATA_WIDTH     (DW),
        .ACC_WIDTH      (ACW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .match_valid_i (match_valid_i),
        .match_addr_i  (match_addr_i),
        .last_i        (last_i),
        .ifm_map_i     (ifm_map_i),
        .flt_map_i     (flt_map_i),
        .ifm_data_i    (ifm_data_i),
        .flt_data_i    (flt_data_i),
        .result_valid_o(result_valid_o),
        .result_o      (result_o),
        .match_cnt_o   (match_cnt_o),
        .busy_o        (busy_o)
    );

    task automatic set_entry(input int k, input int iv, input int fv);
        ifm_data_i[k*DW +: DW] = DW'(iv);
        flt_data_i[k*DW +: DW] = DW'(fv);
    endtask

    // Full maps make index == address; products at addr 0,1,2,3,7 are 6,7,-5,9,-33.
    task automatic load_full();
        ifm_map_i = '1;
        flt_map_i = '1;
        set_entry(0, 2, 3);   set_entry(1, 7, 1);   set_entry(2, -5, 1);
        set_entry(3, 9, 1);   set_entry(4, 6, 2);   set_entry(5, 8, 2);
        set_entry(6, 10, 2);  set_entry(7, 11, -3);
    endtask

    task automatic drive(input logic v, input int addr, input logic l);
        @(negedge clk_i);
        match_valid_i = v;
        match_addr_i  = AW'(addr);
        last_i        = l;
    endtask

    // Idles the inputs and returns how many negedges until result_valid_o; 0 on timeout.
    task automatic wait_pulse(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            match_valid_i = 1'b0;
            last_i        = 1'b0;
            if (result_valid_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        match_valid_i = 1'b0; match_addr_i = '0; last_i = 1'b0;
        ifm_map_i = '0; flt_map_i = '0; ifm_data_i = '0; flt_data_i = '0;
        repeat (3) @(negedge clk_i);
        checks++; if (result_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid_o); end
        checks++; if (result_o !== 16'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result_o); end
        checks++; if (match_cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_basic_match();
        int c;
        ifm_map_i = 8'b1011_0110;
        flt_map_i = 8'b0110_0101;
        ifm_data_i = '0; flt_data_i = '0;
        set_entry(1, 3, 4);
        set_entry(3, -2, 0);
        set_entry(2, 0, 5);
        drive(1'b1, 2, 1'b0);
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got=%b exp=1", busy_o); end
        match_valid_i = 1'b1; match_addr_i = AW'(5); last_i = 1'b1;
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", c); end
        checks++; if (result_o !== 16'd2) begin failures++; $display("FAIL basic_result got=%0d exp=2", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd2) begin failures++; $display("FAIL basic_cnt got=%0d exp=2", match_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_empty_chunk();
        int c;
        drive(1'b0, 0, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL empty_latency got=%0d exp=3", c); end
        checks++; if (result_o !== 16'd0) begin failures++; $display("FAIL empty_result got=%0d exp=0", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd0) begin failures++; $display("FAIL empty_cnt got=%0d exp=0", match_cnt_o); end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [ACW-1:0] exp_b;
        exp_b = ACW'(-5);
        load_full();
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 1, 1'b1);
        drive(1'b1, 2, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", c); end
        checks++; if (result_o !== 16'd13) begin failures++; $display("FAIL b2b_result_a got=%0d exp=13", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd2) begin failures++; $display("FAIL b2b_cnt_a got=%0d exp=2", match_cnt_o); end
        @(negedge clk_i);
        checks++; if (result_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid_b got=%b exp=1", result_valid_o); end
        checks++; if (result_o !== exp_b) begin failures++; $display("FAIL b2b_result_b got=%0d exp=-5", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd1) begin failures++; $display("FAIL b2b_cnt_b got=%0d exp=1", match_cnt_o); end
        @(negedge clk_i);
        checks++; if (result_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_pulse_end got=%b exp=0", result_valid_o); end
    endtask

    task automatic test_index_edge();
        int c;
        logic [ACW-1:0] exp_hi;
        exp_hi = ACW'(-33);
        load_full();
        drive(1'b1, 0, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL idx0_latency got=%0d exp=3", c); end
        checks++; if (result_o !== 16'd6) begin failures++; $display("FAIL idx0_result got=%0d exp=6", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd1) begin failures++; $display("FAIL idx0_cnt got=%0d exp=1", match_cnt_o); end
        drive(1'b1, PSS-1, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL idxmax_latency got=%0d exp=3", c); end
        checks++; if (result_o !== exp_hi) begin failures++; $display("FAIL idxmax_result got=%0d exp=-33", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd1) begin failures++; $display("FAIL idxmax_cnt got=%0d exp=1", match_cnt_o); end
    endtask

    task automatic test_reset_mid_chunk();
        int c;
        load_full();
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 1, 1'b0);
        @(negedge clk_i);
        match_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        checks++; if (result_o !== 16'd0) begin failures++; $display("FAIL midrst_result got=%0d exp=0", $signed(result_o)); end
        checks++; if (result_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", result_valid_o); end
        checks++; if (match_cnt_o !== 4'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", match_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        #1 rst_i = 1'b0;
        drive(1'b1, 3, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL postrst_latency got=%0d exp=3", c); end
        checks++; if (result_o !== 16'd9) begin failures++; $display("FAIL postrst_result got=%0d exp=9", $signed(result_o)); end
        checks++; if (match_cnt_o !== 4'd1) begin failures++; $display("FAIL postrst_cnt got=%0d exp=1", match_cnt_o); end
    endtask

    task automatic test_overflow();
        int c;
        logic [ACW-1:0] exp_ovf;
`ifdef SPARSE_MAC_SATURATE_EN
        exp_ovf = 16'd32767;
`else
        exp_ovf = ACW'(-17149);
`endif
        load_full();
        set_entry(4, 127, 127);
        drive(1'b1, 4, 1'b0);
        drive(1'b1, 4, 1'b0);
        drive(1'b1, 4, 1'b1);
        wait_pulse(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL ovf_latency got=%0d exp=3", c); end
        checks++; if (result_o !== exp_ovf) begin failures++; $display("FAIL ovf_result got=%0d exp=%0d", $signed(result_o), $signed(exp_ovf)); end
        checks++; if (match_cnt_o !== 4'd3) begin failures++; $display("FAIL ovf_cnt got=%0d exp=3", match_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_empty_chunk();
        test_back_to_back();
        test_index_edge();
        test_reset_mid_chunk();
        test_overflow();
        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
